// File: rtl/wah.sv
// wah: auto-wah effect built from a Chamberlin state-variable band-pass filter with a wet/dry mix
// Ports:
//   system_clock          single clock, all registers update on its rising edge
//   rst                   synchronous active-high reset
//   sample_in             signed input audio sample, captured mid sample period
//   filter_strength_ratio wet/dry mix, 0 = dry, 15 = 15/16 wet, sampled when the output updates
//   filter_out            registered signed mixed output, updated once per sample period
//   ready_out             set by the first output update, held until reset
// Optional feature: define WAH_LFO_EN to sweep f as a triangle between F_MIN and F_MAX;
// without it f is the fixed mid point (F_MIN+F_MAX)/2.
module wah #(
    parameter int          SAMPLE_WIDTH = 24,
    parameter int          CLK_DIV      = 2000,
    parameter logic [15:0] F_MIN        = 16'd800,
    parameter logic [15:0] F_MAX        = 16'd12000,
    parameter logic [15:0] LFO_STEP     = 16'd4,
    parameter logic [15:0] Q_DAMP       = 16'h4000
) (
    input  logic                           system_clock,
    input  logic                           rst,
    input  logic signed [SAMPLE_WIDTH-1:0] sample_in,
    input  logic [3:0]                     filter_strength_ratio,
    output logic signed [SAMPLE_WIDTH-1:0] filter_out,
    output logic                           ready_out
);
    localparam int SW = SAMPLE_WIDTH + 4;
    localparam int PW = SW + 24;
    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] C0 = CW'(CLK_DIV / 2);
    localparam logic [CW-1:0] C1 = CW'(CLK_DIV / 2 + 1);
    localparam logic [CW-1:0] C2 = CW'(CLK_DIV / 2 + 2);
    localparam logic [CW-1:0] C3 = CW'(CLK_DIV / 2 + 3);
    localparam logic [CW-1:0] C4 = CW'(CLK_DIV / 2 + 4);

    if (CLK_DIV < 16 || CLK_DIV % 2 != 0 || LFO_STEP == 16'd0 || F_MIN >= F_MAX) begin : g_bad_params
        $error("wah: illegal parameter combination");
    end

    logic [CW-1:0]                  cnt;
    logic [CW-1:0]                  cnt_n;
    logic                           sample_clock;
    logic signed [SAMPLE_WIDTH-1:0] x;
    logic signed [SW-1:0]           lp;
    logic signed [SW-1:0]           bp;
    logic signed [SW-1:0]           hp;
    logic [15:0]                    f;
    logic signed [PW-1:0]           f_w, q_w, r_w, ir_w, x_w, lp_w, bp_w, hp_w;
    logic signed [PW-1:0]           lp_n, hp_n, bp_n, mix_n;

    // Clamp a wide intermediate to the symmetric filter-state range.
    function automatic logic signed [SW-1:0] sat_state(input logic signed [PW-1:0] v);
        logic signed [PW-1:0] hi;
        logic signed [PW-1:0] r;
        hi = PW'({(SW-1){1'b1}});
        r = v > hi ? hi : v < -hi ? -hi : v;
        return r[SW-1:0];
    endfunction

    // Clamp the mix to the full two's complement output range.
    function automatic logic signed [SAMPLE_WIDTH-1:0] sat_out(input logic signed [PW-1:0] v);
        logic signed [PW-1:0] hi;
        logic signed [PW-1:0] lo;
        logic signed [PW-1:0] r;
        hi = PW'({(SAMPLE_WIDTH-1){1'b1}});
        lo = ~hi;
        r = v > hi ? hi : v < lo ? lo : v;
        return r[SAMPLE_WIDTH-1:0];
    endfunction

    assign cnt_n = cnt == LAST ? '0 : cnt + 1'b1;

    // Everything is widened to PW bits so products never lose bits before the shift.
    always_comb begin
        f_w = PW'($signed({1'b0, f}));
        q_w = PW'($signed({1'b0, Q_DAMP}));
        r_w = PW'($signed({1'b0, filter_strength_ratio}));
        ir_w = PW'($signed(6'd16 - {2'b00, filter_strength_ratio}));
        x_w = PW'(x);
        lp_w = PW'(lp);
        bp_w = PW'(bp);
        hp_w = PW'(hp);
        lp_n = lp_w + ((f_w * bp_w) >>> 16);
        hp_n = x_w - lp_w - ((q_w * bp_w) >>> 15);
        bp_n = bp_w + ((f_w * hp_w) >>> 16);
        mix_n = (bp_w * r_w + x_w * ir_w) >>> 4;
    end

    // One SVF stage per cycle after the mid-period capture; output and ready at the fourth.
    always_ff @(posedge system_clock) begin
        if (rst) begin
            cnt <= '0;
            sample_clock <= 1'b0;
            x <= '0;
            lp <= '0;
            bp <= '0;
            hp <= '0;
            filter_out <= '0;
            ready_out <= 1'b0;
        end else begin
            cnt <= cnt_n;
            sample_clock <= cnt_n < C0;
            if (cnt == C0) x <= sample_in;
            if (cnt == C1) lp <= sat_state(lp_n);
            if (cnt == C2) hp <= sat_state(hp_n);
            if (cnt == C3) bp <= sat_state(bp_n);
            if (cnt == C4) begin
                filter_out <= sat_out(mix_n);
                ready_out <= 1'b1;
            end
        end
    end

`ifdef WAH_LFO_EN
    logic dir_down;
    logic at_top;
    logic at_bot;

    // Compare against the bound minus the step so the arithmetic never wraps.
    assign at_top = f >= F_MAX - LFO_STEP;
    assign at_bot = f <= F_MIN + LFO_STEP;

    always_ff @(posedge system_clock) begin
        if (rst) begin
            f <= F_MIN;
            dir_down <= 1'b0;
        end else if (cnt == C4) begin
            f <= dir_down ? (at_bot ? F_MIN : f - LFO_STEP) : (at_top ? F_MAX : f + LFO_STEP);
            dir_down <= dir_down ? !at_bot : at_top;
        end
    end
`else
    localparam logic [16:0] F_SUM = {1'b0, F_MIN} + {1'b0, F_MAX};
    assign f = F_SUM[16:1];
`endif
endmodule

// File: tb/tb_wah.sv
// tb_wah: self-checking bench for wah with a reference model feeding an expected-value queue
module tb_wah;
    localparam int W = 24;
    localparam int CLK_DIV = 2000;
    localparam int C4 = CLK_DIV / 2 + 4;
    localparam longint LIM = (64'sd1 <<< 27) - 1;
`ifdef WAH_LFO_EN
    localparam longint F_INIT = 800;
`else
    localparam longint F_INIT = 6400;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [W-1:0] sample_in = '0;
    logic [3:0] ratio = '0;
    logic [W-1:0] filter_out;
    logic ready_out;
    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];
    longint m_lp, m_bp, m_f;
    bit m_dn;

    wah dut (
        .system_clock(clk),
        .rst(rst),
        .sample_in(sample_in),
        .filter_strength_ratio(ratio),
        .filter_out(filter_out),
        .ready_out(ready_out)
    );

    always #5 clk = ~clk;

    function automatic longint satv(input longint v, input longint lo, input longint hi);
        return v > hi ? hi : (v < lo ? lo : v);
    endfunction

    task automatic model_reset();
        m_lp = 0;
        m_bp = 0;
        m_f = F_INIT;
        m_dn = 0;
        exp_q.delete();
    endtask

    task automatic model_step(input logic [W-1:0] xv, input logic [3:0] r, output logic [W-1:0] e);
        longint xl, hp, mix;
        xl = longint'($signed(xv));
        m_lp = satv(m_lp + ((m_f * m_bp) >>> 16), -LIM, LIM);
        hp = satv(xl - m_lp - ((longint'(16384) * m_bp) >>> 15), -LIM, LIM);
        m_bp = satv(m_bp + ((m_f * hp) >>> 16), -LIM, LIM);
        mix = (m_bp * longint'(r) + xl * (16 - longint'(r))) >>> 4;
        e = W'(satv(mix, -(64'sd1 <<< 23), (64'sd1 <<< 23) - 1));
`ifdef WAH_LFO_EN
        if (!m_dn) begin
            if (m_f >= 12000 - 4) begin m_f = 12000; m_dn = 1; end
            else m_f = m_f + 4;
        end else begin
            if (m_f <= 800 + 4) begin m_f = 800; m_dn = 0; end
            else m_f = m_f - 4;
        end
`endif
    endtask

    task automatic drive_sample(input logic [W-1:0] xv, input logic [3:0] r);
        logic [W-1:0] e;
        sample_in = xv;
        ratio = r;
        model_step(xv, r, e);
        exp_q.push_back(e);
    endtask

    task automatic wait_update(output bit ok);
        ok = 0;
        for (int i = 0; i < 3 * CLK_DIV && !ok; i++) begin
            @(negedge clk);
            if (int'(dut.cnt) == C4 && !rst) begin
                @(posedge clk);
                #1;
                ok = 1;
            end
        end
    endtask

    task automatic apply_reset(input int n);
        rst = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (filter_out !== '0 || ready_out !== 1'b0 || dut.sample_clock !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold cycle %0d: out=%h ready=%b sclk=%b, want 0/0/0", i, filter_out, ready_out, dut.sample_clock);
            end
        end
        checks++;
        if (int'(dut.cnt) != 0 || longint'(dut.f) != F_INIT) begin
            errors++;
            $display("FAIL reset_state: cnt=%0d f=%0d, want 0 and %0d", dut.cnt, dut.f, F_INIT);
        end
    endtask

    task automatic test_latency();
        logic [W-1:0] e;
        model_reset();
        drive_sample(24'h100000, 4'd0);
        rst = 1'b0;
        @(posedge clk);
        repeat (1003) @(posedge clk);
        #1;
        checks++;
        if (ready_out !== 1'b0) begin
            errors++;
            $display("FAIL latency_early_ready: ready=%b 1003 cycles after release, want 0", ready_out);
        end
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        checks++;
        if (ready_out !== 1'b1 || filter_out !== e || e !== 24'h100000) begin
            errors++;
            $display("FAIL latency_first_out: ready=%b out=%h, want 1 and %h", ready_out, filter_out, 24'h100000);
        end
    endtask

    task automatic test_sample_clock();
        logic [W-1:0] e;
        bit found, prev;
        int hi_n, per_n;
        drive_sample(24'h100000, 4'd0);
        found = 0;
        prev = dut.sample_clock;
        for (int i = 0; i < 3 * CLK_DIV && !found; i++) begin
            @(posedge clk);
            #1;
            found = !prev && dut.sample_clock;
            prev = dut.sample_clock;
        end
        hi_n = 0;
        for (int i = 0; i < 3 * CLK_DIV && dut.sample_clock; i++) begin
            @(posedge clk);
            #1;
            hi_n++;
        end
        per_n = hi_n;
        for (int i = 0; i < 3 * CLK_DIV && !dut.sample_clock; i++) begin
            @(posedge clk);
            #1;
            per_n++;
        end
        checks++;
        if (!found || hi_n != CLK_DIV / 2 || per_n != CLK_DIV) begin
            errors++;
            $display("FAIL sample_clock: rise=%b high=%0d period=%0d, want 1/%0d/%0d", found, hi_n, per_n, CLK_DIV / 2, CLK_DIV);
        end
        e = exp_q.pop_front();
        checks++;
        if (filter_out !== e) begin
            errors++;
            $display("FAIL sclk_window_out: out=%h, want %h", filter_out, e);
        end
    endtask

    task automatic test_zero();
        logic [W-1:0] e;
        bit ok;
        apply_reset(3);
        for (int i = 0; i < 3; i++) begin
            drive_sample('0, 4'd8);
            wait_update(ok);
            e = exp_q.pop_front();
            checks++;
            if (!ok || filter_out !== e || filter_out !== '0 || ready_out !== 1'b1) begin
                errors++;
                $display("FAIL zero_in sample %0d: ok=%b out=%h ready=%b, want 000000 and 1", i, ok, filter_out, ready_out);
            end
        end
    endtask

    task automatic test_saturation();
        logic [W-1:0] e;
        bit ok;
        apply_reset(3);
        for (int i = 0; i < 16; i++) begin
            drive_sample(i % 2 ? 24'h800000 : 24'h7FFFFF, 4'd15);
            wait_update(ok);
            e = exp_q.pop_front();
            checks++;
            if (!ok || filter_out !== e) begin
                errors++;
                $display("FAIL saturation sample %0d: ok=%b out=%h, want %h", i, ok, filter_out, e);
            end
        end
    endtask

    task automatic test_ratio_glitch();
        logic [W-1:0] e;
        bit ok;
        for (int i = 0; i < 2; i++) begin
            drive_sample(i ? 24'hF00000 : 24'h200000, 4'd4);
            repeat (300) @(negedge clk);
            ratio = 4'd15;
            repeat (5) @(negedge clk);
            ratio = 4'd4;
            wait_update(ok);
            e = exp_q.pop_front();
            checks++;
            if (!ok || filter_out !== e) begin
                errors++;
                $display("FAIL ratio_glitch sample %0d: ok=%b out=%h, want %h", i, ok, filter_out, e);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] e;
        bit ok;
        for (int i = 0; i < 4; i++) begin
            drive_sample(W'($urandom), 4'($urandom_range(0, 15)));
            wait_update(ok);
            e = exp_q.pop_front();
            checks++;
            if (!ok || filter_out !== e) begin
                errors++;
                $display("FAIL back_to_back sample %0d: ok=%b out=%h, want %h", i, ok, filter_out, e);
            end
        end
    endtask

    task automatic test_mid_reset();
        logic [W-1:0] e;
        bit ok, hit;
        drive_sample(24'h123456, 4'd9);
        wait_update(ok);
        e = exp_q.pop_front();
        checks++;
        if (!ok || filter_out !== e) begin
            errors++;
            $display("FAIL pre_abort_out: ok=%b out=%h, want %h", ok, filter_out, e);
        end
        sample_in = 24'h654321;
        hit = 0;
        for (int i = 0; i < 3 * CLK_DIV && !hit; i++) begin
            @(negedge clk);
            hit = int'(dut.cnt) == CLK_DIV / 2 + 2;
        end
        rst = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
            checks++;
            if (!hit || filter_out !== '0 || ready_out !== 1'b0 || dut.sample_clock !== 1'b0 || int'(dut.cnt) != 0
                || dut.x !== '0 || dut.lp !== '0 || dut.bp !== '0 || dut.hp !== '0 || longint'(dut.f) != F_INIT) begin
                errors++;
                $display("FAIL mid_reset: hit=%b out=%h ready=%b sclk=%b cnt=%0d lp=%h bp=%h hp=%h f=%0d, want all reset", hit, filter_out, ready_out, dut.sample_clock, dut.cnt, dut.lp, dut.bp, dut.hp, dut.f);
            end
        end
        rst = 1'b0;
        model_reset();
        drive_sample(24'h0ABCDE, 4'd6);
        wait_update(ok);
        e = exp_q.pop_front();
        checks++;
        if (!ok || filter_out !== e || ready_out !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_out: ok=%b out=%h ready=%b, want %h and 1", ok, filter_out, ready_out, e);
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_sample_clock();
        test_zero();
        test_saturation();
        test_ratio_glitch();
        test_back_to_back();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #990000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
